fpu16_host_link: RTL and testbench
==================================

# fpu16_host_link

Host-side endpoint of the 16-bit FPU chip's 10-bit pin link. It accepts one operation (two 16-bit operands plus a 4-bit opcode) on a valid/ready request port and serializes it as five beats onto the chip's input bus. It then collects the chip's two-beat result from the chip's output bus and returns it on a valid/ready response port with a status code. It lives in the test harness / FPGA carrier and drives the chip's `io_in[9:0]` while listening on `io_out[9:0]`.

## Interface
- `GAP`, default 0: idle cycles (valid low) inserted between consecutive request beats.
- `TIMEOUT_CYCLES`, default 255: maximum consecutive cycles with no response beat before aborting; 0 disables the timeout.
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1 / `req_ready` out 1: request handshake.
- `req_a` in 16, `req_b` in 16, `req_op` in 4: operands and opcode; sampled only on handshake.
- `link_out` out 10: to chip `io_in[9:0]`; [9]=valid, [8]=last, [7:0]=data; registered.
- `link_in` in 10: from chip `io_out[9:0]`; same field layout; same clock domain, no synchronizer.
- `rsp_valid` out 1 / `rsp_ready` in 1: response handshake.
- `rsp_data` out 16: result.
- `rsp_status` out 2: 00 ok, 01 timeout, 10 framing error.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, SEND, WAIT_HI, WAIT_LO, HOLD.
- IDLE: `req_ready`=1. On `req_valid & req_ready`, capture a, b, op → SEND with beat index 0.
- SEND: beats in order A[15:8], A[7:0], B[15:8], B[7:0], {4'b0, op}; valid=1 on each; last=1 only on beat 4. GAP idle beats (`link_out`=0) go between data beats. After beat 4 → WAIT_HI.
- WAIT_HI: first `link_in` beat with [9]=1 carries the result high byte. If [8]=0 → store hi byte, go to WAIT_LO. If [8]=1 → HOLD with status 10.
- WAIT_LO: the next valid beat carries the low byte. If [8]=1 → HOLD with status 00 and rsp_data={hi,lo}. If [8]=0 → HOLD with status 10.
- Valid `link_in` beats seen in IDLE, SEND or HOLD are ignored.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on entry to WAIT_HI and on every valid response beat. Increments each cycle in WAIT_HI/WAIT_LO with no valid beat. When it reaches TIMEOUT_CYCLES → HOLD with status 01.
- Framing error or timeout: `rsp_data`=16'hFFFF.
- HOLD: `rsp_valid`=1; `rsp_data` and `rsp_status` stable until `rsp_ready`. On handshake → IDLE.

## Timing
- Reset values (asynchronous, immediate): state IDLE, `link_out`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_status`=0, `busy`=0, counters 0. `req_ready`=1 from the first clock edge after reset deasserts.
- Reset asserted mid-operation: all of the above take effect without a clock edge. A partially sent frame is abandoned; no completion beat is emitted.
- Request handshake at edge N: beat 0 appears on `link_out` after edge N+1. Beat k appears after edge N+1+k·(GAP+1). `link_out`=0 in the cycle after beat 4.
- State is WAIT_HI in the cycle following beat 4. A response beat present in that cycle is accepted.
- `link_in` is sampled every edge.
- Low byte sampled at edge M: `rsp_valid`=1 after edge M+1.
- Timeout (TIMEOUT_CYCLES=T, no beats): `rsp_valid` rises T+1 cycles after entering WAIT_HI.
- Response handshake at edge R: IDLE after R, so `req_ready`=1 in the following cycle. A new request can be accepted at edge R+1.
- `req_ready`=0 and `busy`=1 from the cycle after acceptance until return to IDLE. Back-to-back throughput is one operation per response handshake.

## Test plan
- Basic op, GAP=0: a=16'h3C00, b=16'h4000, op=4'h0 → `link_out` beats 0x23C, 0x200, 0x240, 0x200, 0x300 on 5 consecutive cycles. Chip model returns 0x242 then 0x300 → rsp_data=16'h4200, status 00, `rsp_valid` one cycle after the low beat.
- GAP=2: same request → each beat separated by exactly 2 cycles of `link_out`=0. Stalling `rsp_ready` low for 10 cycles keeps `rsp_data`/`rsp_status` stable and `req_ready`=0.
- Timeout, TIMEOUT_CYCLES=8: no response → `rsp_valid` 9 cycles after WAIT_HI entry, status 01, data 16'hFFFF. Next request is accepted normally.
- Framing: first response beat 0x3AB (last=1) → status 10, data 16'hFFFF. Separately, second beat 0x2CD (last=0) → status 10.
- Spurious beats: a valid `link_in` beat during SEND and during HOLD → ignored; the result equals the following correct two-beat response.
- Reset asserted during SEND beat 2 → `link_out`=0 and `busy`=0 immediately. After release a fresh request completes correctly.

Source files
------------

// File: rtl/fpu16_host_link.sv
// Host-side endpoint of the FPU chip's 10-bit pin link: serializes one operation
// into five request beats and collects the chip's two-beat result.
module fpu16_host_link #(
    parameter int GAP            = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [3:0]  req_op,
    output logic [9:0]  link_out,
    input  logic [9:0]  link_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        busy
);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam logic [TW-1:0] TO_LIMIT   = TW'(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP);
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_FRAME   = 2'b10;

    typedef enum logic [2:0] {IDLE, SEND, WAIT_HI, WAIT_LO, HOLD} state_t;

    state_t        r_state;
    logic [15:0]   r_a;
    logic [15:0]   r_b;
    logic [3:0]    r_op;
    logic [2:0]    r_beatIdx;
    logic [GW-1:0] r_gapCnt;
    logic [TW-1:0] r_toCnt;
    logic [7:0]    r_hi;
    logic          r_inValid;
    logic          r_inLast;
    logic [7:0]    r_inData;
    logic          r_reqReady;
    logic          r_busy;
    logic          r_rspValid;
    logic [15:0]   r_rspData;
    logic [1:0]    r_rspStatus;
    logic [9:0]    r_linkOut;

    logic [7:0]    w_beatData;
    logic          w_waiting;
    logic          w_timedOut;

    assign req_ready  = r_reqReady;
    assign busy       = r_busy;
    assign rsp_valid  = r_rspValid;
    assign rsp_data   = r_rspData;
    assign rsp_status = r_rspStatus;
    assign link_out   = r_linkOut;

    assign w_waiting  = (r_state == WAIT_HI) || (r_state == WAIT_LO);
    assign w_timedOut = (TIMEOUT_CYCLES != 0) && (r_toCnt == TO_LIMIT);

    always_comb begin
        w_beatData = 8'h00;
        case (r_beatIdx)
            3'd0:    w_beatData = r_a[15:8];
            3'd1:    w_beatData = r_a[7:0];
            3'd2:    w_beatData = r_b[15:8];
            3'd3:    w_beatData = r_b[7:0];
            3'd4:    w_beatData = {4'b0000, r_op};
            default: w_beatData = 8'h00;
        endcase
    end

    // Response beats are registered first; only beats arriving while waiting are kept,
    // so anything the chip sends during SEND or HOLD never reaches the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_inValid <= 1'b0;
            r_inLast  <= 1'b0;
            r_inData  <= 8'h00;
        end else begin
            r_inValid <= link_in[9] && w_waiting;
            r_inLast  <= link_in[8];
            r_inData  <= link_in[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_op        <= 4'h0;
            r_beatIdx   <= 3'd0;
            r_gapCnt    <= '0;
            r_toCnt     <= '0;
            r_hi        <= 8'h00;
            r_reqReady  <= 1'b0;
            r_busy      <= 1'b0;
            r_rspValid  <= 1'b0;
            r_rspData   <= 16'h0000;
            r_rspStatus <= 2'b00;
            r_linkOut   <= 10'h000;
        end else begin
            case (r_state)
                IDLE: begin
                    r_reqReady <= 1'b1;
                    if (req_valid && r_reqReady) begin
                        r_a        <= req_a;
                        r_b        <= req_b;
                        r_op       <= req_op;
                        r_beatIdx  <= 3'd0;
                        r_gapCnt   <= '0;
                        r_reqReady <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (r_gapCnt != '0) begin
                        r_linkOut <= 10'h000;
                        r_gapCnt  <= r_gapCnt - 1'b1;
                    end else if (r_beatIdx == 3'd5) begin
                        r_linkOut <= 10'h000;
                        r_toCnt   <= '0;
                        r_state   <= WAIT_HI;
                    end else begin
                        r_linkOut <= {1'b1, (r_beatIdx == 3'd4), w_beatData};
                        r_beatIdx <= r_beatIdx + 3'd1;
                        r_gapCnt  <= (r_beatIdx == 3'd4) ? '0 : GAP_RELOAD;
                    end
                end
                // Both wait states share the beat decode and timeout; the state only
                // decides whether a non-last beat is a valid high byte or a framing error.
                WAIT_HI, WAIT_LO: begin
                    if (r_inValid) begin
                        r_toCnt <= '0;
                        if ((r_state == WAIT_HI) && !r_inLast) begin
                            r_hi    <= r_inData;
                            r_state <= WAIT_LO;
                        end else begin
                            r_state    <= HOLD;
                            r_rspValid <= 1'b1;
                            if ((r_state == WAIT_LO) && r_inLast) begin
                                r_rspStatus <= ST_OK;
                                r_rspData   <= {r_hi, r_inData};
                            end else begin
                                r_rspStatus <= ST_FRAME;
                                r_rspData   <= 16'hFFFF;
                            end
                        end
                    end else if (w_timedOut) begin
                        r_state     <= HOLD;
                        r_rspValid  <= 1'b1;
                        r_rspStatus <= ST_TIMEOUT;
                        r_rspData   <= 16'hFFFF;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_reqReady <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu16_host_link.sv
// Scoreboard bench for fpu16_host_link: a no-gap instance (short timeout) and a
// two-cycle-gap instance share one harness, selected by 'sel'.
`timescale 1ns/1ps
module tb_fpu16_host_link;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  status;
    } rsp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        reqValid = 1'b0;
    logic [15:0] reqA = 16'h0;
    logic [15:0] reqB = 16'h0;
    logic [3:0]  reqOp = 4'h0;
    logic [9:0]  linkIn = 10'h0;
    logic        rspReady = 1'b0;

    logic        reqReady0, rspValid0, busy0, reqReady1, rspValid1, busy1;
    logic [9:0]  linkOut0, linkOut1;
    logic [15:0] rspData0, rspData1;
    logic [1:0]  rspStatus0, rspStatus1;

    logic        reqReady, rspValid, busy;
    logic [9:0]  linkOut;
    logic [15:0] rspData;
    logic [1:0]  rspStatus;

    logic [9:0]  beatQ[$];
    rsp_t        rspQ[$];
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    fpu16_host_link #(.GAP(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clock(clock), .reset(reset),
        .req_valid(reqValid & ~sel), .req_ready(reqReady0),
        .req_a(reqA), .req_b(reqB), .req_op(reqOp),
        .link_out(linkOut0), .link_in(sel ? 10'h000 : linkIn),
        .rsp_valid(rspValid0), .rsp_ready(rspReady & ~sel),
        .rsp_data(rspData0), .rsp_status(rspStatus0), .busy(busy0)
    );

    fpu16_host_link #(.GAP(2)) dut1 (
        .clock(clock), .reset(reset),
        .req_valid(reqValid & sel), .req_ready(reqReady1),
        .req_a(reqA), .req_b(reqB), .req_op(reqOp),
        .link_out(linkOut1), .link_in(sel ? linkIn : 10'h000),
        .rsp_valid(rspValid1), .rsp_ready(rspReady & sel),
        .rsp_data(rspData1), .rsp_status(rspStatus1), .busy(busy1)
    );

    assign reqReady  = sel ? reqReady1  : reqReady0;
    assign rspValid  = sel ? rspValid1  : rspValid0;
    assign busy      = sel ? busy1      : busy0;
    assign linkOut   = sel ? linkOut1   : linkOut0;
    assign rspData   = sel ? rspData1   : rspData0;
    assign rspStatus = sel ? rspStatus1 : rspStatus0;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Drives a request until accepted and queues the five beats it must produce.
    task automatic sendRequest(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
        int waitCnt;
        reqA = a;
        reqB = b;
        reqOp = op;
        reqValid = 1'b1;
        beatQ.push_back({2'b10, a[15:8]});
        beatQ.push_back({2'b10, a[7:0]});
        beatQ.push_back({2'b10, b[15:8]});
        beatQ.push_back({2'b10, b[7:0]});
        beatQ.push_back({2'b11, 4'h0, op});
        waitCnt = 0;
        while (reqReady !== 1'b1 && waitCnt < 20) begin
            tick;
            waitCnt++;
        end
        checks++;
        if (reqReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reqAccept: req_ready=%b, required 1 within 20 cycles", reqReady);
        end
        tick;
        reqValid = 1'b0;
    endtask

    // Checks every link_out cycle from acceptance up to the first WAIT_HI cycle.
    task automatic sendBeats(input int gap, input int spurAt);
        int total;
        logic [9:0] expBeat;
        total = 4 * (gap + 1) + 2;
        for (int c = 1; c <= total; c++) begin
            tick;
            linkIn = (c == spurAt) ? 10'h355 : 10'h000;
            expBeat = 10'h000;
            if (c < total && ((c - 1) % (gap + 1)) == 0) begin
                if (beatQ.size() > 0) expBeat = beatQ.pop_front();
                else expBeat = 10'h3FF;
            end
            checks++;
            if (linkOut !== expBeat) begin
                failures++;
                $display("[TB] FAIL linkBeat c=%0d: link_out=%h, required %h", c, linkOut, expBeat);
            end
            if (c == 1) begin
                checks++;
                if (reqReady !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL busyWhileSend: req_ready=%b busy=%b, required 0/1", reqReady, busy);
                end
            end
        end
        linkIn = 10'h000;
    endtask

    // Chip model: drives one or two response beats and queues the result they imply.
    task automatic chipReply(input logic [9:0] b0, input logic [9:0] b1, input bit two);
        rsp_t e;
        if (b0[8]) e = {16'hFFFF, 2'b10};
        else if (b1[8]) e = {b0[7:0], b1[7:0], 2'b00};
        else e = {16'hFFFF, 2'b10};
        rspQ.push_back(e);
        linkIn = b0;
        tick;
        if (two) begin
            linkIn = b1;
            tick;
        end
        linkIn = 10'h000;
    endtask

    task automatic checkResponse(input string name, input int expLat, input int stall, input logic [9:0] holdBeat);
        int cnt;
        rsp_t e;
        cnt = 0;
        while (rspValid !== 1'b1 && cnt < 40) begin
            tick;
            cnt++;
        end
        checks++;
        if (rspValid !== 1'b1 || cnt != expLat) begin
            failures++;
            $display("[TB] FAIL %s latency: rsp_valid=%b after %0d cycles, required 1 after %0d", name, rspValid, cnt, expLat);
        end
        if (rspQ.size() > 0) e = rspQ.pop_front();
        else e = {16'hxxxx, 2'bxx};
        checks++;
        if (rspData !== e.data) begin
            failures++;
            $display("[TB] FAIL %s data: rsp_data=%h, required %h", name, rspData, e.data);
        end
        checks++;
        if (rspStatus !== e.status) begin
            failures++;
            $display("[TB] FAIL %s status: rsp_status=%b, required %b", name, rspStatus, e.status);
        end
        for (int s = 0; s < stall; s++) begin
            linkIn = (s == 0) ? holdBeat : 10'h000;
            tick;
            checks++;
            if (rspValid !== 1'b1 || rspData !== e.data || rspStatus !== e.status || reqReady !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s hold s=%0d: valid=%b data=%h status=%b req_ready=%b, required 1/%h/%b/0",
                         name, s, rspValid, rspData, rspStatus, reqReady, e.data, e.status);
            end
        end
        linkIn = 10'h000;
        rspReady = 1'b1;
        tick;
        rspReady = 1'b0;
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s release: valid=%b req_ready=%b busy=%b, required 0/1/0", name, rspValid, reqReady, busy);
        end
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if (linkOut !== 10'h0 || rspValid !== 1'b0 || rspData !== 16'h0 || rspStatus !== 2'b0 ||
            busy !== 1'b0 || reqReady !== 1'b0) begin
            failures++;
            $display("[TB] FAIL resetValues: link=%h valid=%b data=%h status=%b busy=%b ready=%b, required all 0",
                     linkOut, rspValid, rspData, rspStatus, busy, reqReady);
        end
        tick;
        reset = 1'b0;
        tick;
        checks++;
        if (reqReady !== 1'b1) begin
            failures++;
            $display("[TB] FAIL readyAfterReset: req_ready=%b, required 1", reqReady);
        end
    endtask

    task automatic test_basic;
        sel = 1'b0;
        sendRequest(16'h3C00, 16'h4000, 4'h0);
        sendBeats(0, 0);
        chipReply(10'h242, 10'h300, 1'b1);
        checkResponse("basic", 1, 0, 10'h000);
    endtask

    task automatic test_gap_stall;
        sel = 1'b1;
        sendRequest(16'h3C00, 16'h4000, 4'h0);
        sendBeats(2, 0);
        chipReply(10'h2AB, 10'h3CD, 1'b1);
        checkResponse("gapStall", 1, 10, 10'h000);
        sel = 1'b0;
    endtask

    task automatic test_timeout;
        sendRequest(16'h1111, 16'h2222, 4'h5);
        sendBeats(0, 0);
        rspQ.push_back({16'hFFFF, 2'b01});
        checkResponse("timeout", 9, 0, 10'h000);
        sendRequest(16'h1234, 16'h5678, 4'h3);
        sendBeats(0, 0);
        chipReply(10'h201, 10'h302, 1'b1);
        checkResponse("afterTimeout", 1, 0, 10'h000);
    endtask

    task automatic test_framing;
        sendRequest(16'hAAAA, 16'h5555, 4'h1);
        sendBeats(0, 0);
        chipReply(10'h3AB, 10'h000, 1'b0);
        checkResponse("frameFirstLast", 1, 0, 10'h000);
        sendRequest(16'h0F0F, 16'hF0F0, 4'h2);
        sendBeats(0, 0);
        chipReply(10'h212, 10'h2CD, 1'b1);
        checkResponse("frameSecondNotLast", 1, 0, 10'h000);
    endtask

    task automatic test_spurious;
        sendRequest(16'hABCD, 16'h0123, 4'hF);
        sendBeats(0, 2);
        chipReply(10'h211, 10'h322, 1'b1);
        checkResponse("spuriousSend", 1, 3, 10'h3EE);
        sendRequest(16'h7777, 16'h8888, 4'h4);
        sendBeats(0, 0);
        chipReply(10'h2C4, 10'h355, 1'b1);
        checkResponse("spuriousHold", 1, 0, 10'h000);
    endtask

    task automatic test_reset_mid;
        sendRequest(16'h3C00, 16'h4000, 4'h0);
        tick;
        tick;
        tick;
        checks++;
        if (linkOut !== 10'h240) begin
            failures++;
            $display("[TB] FAIL midBeat2: link_out=%h, required 240", linkOut);
        end
        beatQ.delete();
        reset = 1'b1;
        #1;
        checks++;
        if (linkOut !== 10'h0 || busy !== 1'b0 || rspValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midReset: link=%h busy=%b valid=%b, required 0/0/0", linkOut, busy, rspValid);
        end
        tick;
        tick;
        reset = 1'b0;
        checks++;
        if (reqReady !== 1'b0 || linkOut !== 10'h0) begin
            failures++;
            $display("[TB] FAIL midResetHold: req_ready=%b link=%h, required 0/000", reqReady, linkOut);
        end
        tick;
        sendRequest(16'h4500, 16'h4600, 4'h1);
        sendBeats(0, 0);
        chipReply(10'h24B, 10'h380, 1'b1);
        checkResponse("afterMidReset", 1, 0, 10'h000);
    endtask

    task automatic test_back_to_back;
        sendRequest(16'hDEAD, 16'hBEEF, 4'h7);
        sendBeats(0, 0);
        chipReply(10'h2DE, 10'h3AD, 1'b1);
        checkResponse("b2bFirst", 1, 0, 10'h000);
        sendRequest(16'hCAFE, 16'hF00D, 4'h8);
        sendBeats(0, 0);
        chipReply(10'h2CA, 10'h3FE, 1'b1);
        checkResponse("b2bSecond", 1, 0, 10'h000);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_gap_stall;
        test_timeout;
        test_framing;
        test_spurious;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within 200000 ns");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
